coeff_token_ctrl: RTL and testbench
===================================

COEFF_TOKEN_CTRL -- requirements
Module: coeff_token_ctrl

Interface
REQ-001 Parameter WIN_W, default 16: bitstream window width; MSB is the next unread bit.
REQ-002 Clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  one-cycle request to decode one coeff_token.
REQ-005 nC  input  5  signed two's-complement context (-1..16); -1 = chroma DC.
REQ-006 Window  input  WIN_W  bitstream bits, MSB-first.
REQ-007 WindowValid  input  1  Window holds at least 16 valid bits.
REQ-008 LutTable  output  3  table select to the external LUT bank.
REQ-009 LutZeros  output  4  leading-zero count of Window.
REQ-010 LutBits  output  4  the 4 bits following the first 1.
REQ-011 LutTotalCoeff  input  5  LUT result.
REQ-012 LutTrailingOnes  input  2  LUT result.
REQ-013 LutNumShift  input  5  LUT result.
REQ-014 LutHit  input  1  LUT matched the code.
REQ-015 ShiftEn  output  1  request to advance the bitstream by ShiftAmt.
REQ-016 ShiftAmt  output  5  bits to consume.
REQ-017 ShiftAck  input  1  bitstream buffer accepted the shift.
REQ-018 TotalCoeff  output  5  decoded value, held until the next Done.
REQ-019 TrailingOnes  output  2  decoded value, held until the next Done.
REQ-020 Done  output  1  one-cycle pulse; results valid.
REQ-021 Busy  output  1  high in any state other than IDLE.
REQ-022 Error  output  1  one-cycle pulse on an illegal code (only when ERR_EN is compiled in).

Function
REQ-023 FSM states: IDLE, WAIT_WIN, LOOKUP, CAPTURE, SHIFT, DONE.
REQ-024 IDLE: Start transitions to WAIT_WIN; nC is registered on the same edge.
REQ-025 WAIT_WIN: transition to LOOKUP on the first cycle with WindowValid=1; otherwise remain.
REQ-026 Table rule from registered nC: 0..1 -> 0, 2..3 -> 1, 4..7 -> 2, >=8 -> 3 (fixed-length), -1 -> 4; other negatives -> 4.
REQ-027 LOOKUP: LutTable, LutZeros and LutBits are driven combinationally from the registered Window.
REQ-028 LOOKUP: LutZeros = leading-zero count, saturated at 15.
REQ-029 LOOKUP: LutBits = the 4 bits after the first 1, zero-filled past the window end.
REQ-030 CAPTURE, tables 0/1/2/4: register LutTotalCoeff, LutTrailingOnes and LutNumShift.
REQ-031 CAPTURE, table 3: no LUT is used; with code = Window[15:10], 6'b000011 gives TotalCoeff=0, TrailingOnes=0.
REQ-032 CAPTURE, table 3, any other code: TotalCoeff = code[5:2]+1, TrailingOnes = code[1:0]; shift is 6.
REQ-033 SHIFT: ShiftEn=1 and ShiftAmt stable until the cycle ShiftAck=1; next state DONE.
REQ-034 DONE: Done=1 for exactly one cycle, then IDLE.
REQ-035 Latency with WindowValid already high: Start at cycle 0, ShiftEn from cycle 3, Done the cycle after ShiftAck.
REQ-036 Start while Busy is ignored; ShiftAck outside SHIFT is ignored.
REQ-037 Simultaneous ShiftAck and Reset: Reset wins.

Reset
REQ-038 On Reset: state=IDLE; ShiftEn, Done, Error, Busy = 0.
REQ-039 On Reset: TotalCoeff=0, TrailingOnes=0, ShiftAmt=0, LutTable=0, LutZeros=0, LutBits=0.
REQ-040 Reset mid-operation aborts with no further shift request; ShiftEn is low from the next cycle.

Configuration
REQ-041 Macro COEFF_TOKEN_CTRL_ERR_EN, defined: in CAPTURE, LutHit=0 or LutZeros>14 (tables 0/1/2/4) pulses Error for one cycle and returns to IDLE.
REQ-042 With the macro defined, the error path issues no shift and no Done, and result outputs hold their previous values.
REQ-043 Macro undefined: LutHit is ignored, LUT values are used as-is, and Error is tied 0.

Structure
REQ-044 Shared package cavlc_pkg holds FSM state encoding, the table codes (T_NC0, T_NC2, T_NC4, T_FLC, T_CDC) and the FLC width constant 6.
REQ-045 One sub-module, clz16: combinational leading-zero count with 4-bit saturating output and the 4-bit post-one extract.

Verification
REQ-046 nC=0, Window=16'h8000, LUT model returns (0,0,1) -> LutTable=0, LutZeros=0, ShiftAmt=1, Done with TotalCoeff=0, TrailingOnes=0.
REQ-047 nC=8, Window=16'h0C00 (code 000011) -> TotalCoeff=0, TrailingOnes=0, ShiftAmt=6; nC=8, Window=16'h1400 (code 000101) -> TotalCoeff=2, TrailingOnes=1, ShiftAmt=6.
REQ-048 nC=3 -> LutTable=1; nC=5 -> 2; nC=-1 (5'h1F) -> 4; Window=16'h0001 -> LutZeros=15, LutBits=0.
REQ-049 ShiftAck held low for 5 cycles -> ShiftEn and ShiftAmt stable for all 5; a Start pulse during this time is ignored; Done occurs 1 cycle after ShiftAck.
REQ-050 ERR_EN defined, LutHit=0 -> Error pulse, no ShiftEn, no Done, back to IDLE; ERR_EN undefined -> normal Done with LUT values.
REQ-051 Reset asserted during SHIFT -> next cycle ShiftEn=0, Busy=0, all outputs at reset values; a subsequent Start decodes correctly.

Source files
------------

// File: rtl/cavlc_pkg.sv
// Shared CAVLC definitions: coeff_token FSM encoding, VLC table codes and table selection.
package cavlc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WIN,
    S_LOOKUP,
    S_CAPTURE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [2:0] T_NC0 = 3'd0;
  localparam logic [2:0] T_NC2 = 3'd1;
  localparam logic [2:0] T_NC4 = 3'd2;
  localparam logic [2:0] T_FLC = 3'd3;
  localparam logic [2:0] T_CDC = 3'd4;

  localparam int FLC_W = 6;

  // Any negative context selects the chroma DC table.
  function automatic logic [2:0] table_sel(input logic signed [4:0] nc);
    if (nc < 5'sd0)      return T_CDC;
    else if (nc < 5'sd2) return T_NC0;
    else if (nc < 5'sd4) return T_NC2;
    else if (nc < 5'sd8) return T_NC4;
    else                 return T_FLC;
  endfunction

endpackage

// File: rtl/clz16.sv
// Leading-zero count of a 16-bit window (saturated at 15) plus the 4 bits after the first one.
module clz16 (
  input  logic [15:0] w,
  output logic [3:0]  zeros,
  output logic [3:0]  bits
);

  logic [4:0]  lz;
  logic [15:0] rest;

  always_comb begin
    lz = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (w[i]) lz = 5'(15 - i);
    end
    zeros = (lz > 5'd15) ? 4'd15 : lz[3:0];
    // Shifting past the leading one zero-fills anything beyond the window end.
    rest  = (lz == 5'd16) ? 16'd0 : (w << (lz + 5'd1));
    bits  = rest[15:12];
  end

endmodule

// File: rtl/coeff_token_ctrl.sv
// CAVLC coeff_token decode controller: drives an external LUT bank, handles the FLC table inline.
// Optional illegal-code detection when COEFF_TOKEN_CTRL_ERR_EN is defined.
module coeff_token_ctrl
  import cavlc_pkg::*;
#(
  parameter int WIN_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic signed [4:0] nC,
  input  logic [WIN_W-1:0]  Window,
  input  logic              WindowValid,
  output logic [2:0]        LutTable,
  output logic [3:0]        LutZeros,
  output logic [3:0]        LutBits,
  input  logic [4:0]        LutTotalCoeff,
  input  logic [1:0]        LutTrailingOnes,
  input  logic [4:0]        LutNumShift,
  input  logic              LutHit,
  output logic              ShiftEn,
  output logic [4:0]        ShiftAmt,
  input  logic              ShiftAck,
  output logic [4:0]        TotalCoeff,
  output logic [1:0]        TrailingOnes,
  output logic              Done,
  output logic              Busy,
  output logic              Error
);

  state_t             state;
  logic signed [4:0]  nc_q;
  logic [15:0]        win_q;
  logic [4:0]         cap_tc;
  logic [1:0]         cap_t1;
  logic [2:0]         tbl;
  logic [3:0]         clz_zeros;
  logic [3:0]         clz_bits;
  logic [5:0]         code;

  assign tbl  = table_sel(nc_q);
  assign code = win_q[15:10];

  clz16 u_clz (
    .w     (win_q),
    .zeros (clz_zeros),
    .bits  (clz_bits)
  );

  // LUT address is held through CAPTURE so the LUT result is stable when sampled.
  always_comb begin
    LutTable = '0;
    LutZeros = '0;
    LutBits  = '0;
    if (state == S_LOOKUP || state == S_CAPTURE) begin
      LutTable = tbl;
      LutZeros = clz_zeros;
      LutBits  = clz_bits;
    end
  end

`ifdef COEFF_TOKEN_CTRL_ERR_EN
  logic err_q;
  assign Error = err_q;
`else
  logic unused_hit;
  assign unused_hit = LutHit;
  assign Error = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= S_IDLE;
      nc_q         <= '0;
      win_q        <= '0;
      cap_tc       <= '0;
      cap_t1       <= '0;
      ShiftEn      <= 1'b0;
      ShiftAmt     <= '0;
      TotalCoeff   <= '0;
      TrailingOnes <= '0;
      Done         <= 1'b0;
      Busy         <= 1'b0;
`ifdef COEFF_TOKEN_CTRL_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
`ifdef COEFF_TOKEN_CTRL_ERR_EN
      err_q <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (Start) begin
            nc_q  <= nC;
            Busy  <= 1'b1;
            state <= S_WAIT_WIN;
          end
        end
        S_WAIT_WIN: begin
          if (WindowValid) begin
            win_q <= Window[WIN_W-1 -: 16];
            state <= S_LOOKUP;
          end
        end
        S_LOOKUP: state <= S_CAPTURE;
        S_CAPTURE: begin
          if (tbl == T_FLC) begin
            if (code == 6'b000011) begin
              cap_tc <= '0;
              cap_t1 <= '0;
            end else begin
              cap_tc <= {1'b0, code[5:2]} + 5'd1;
              cap_t1 <= code[1:0];
            end
            ShiftAmt <= 5'(FLC_W);
            ShiftEn  <= 1'b1;
            state    <= S_SHIFT;
          end
`ifdef COEFF_TOKEN_CTRL_ERR_EN
          else if (!LutHit || clz_zeros > 4'd14) begin
            err_q <= 1'b1;
            Busy  <= 1'b0;
            state <= S_IDLE;
          end
`endif
          else begin
            cap_tc   <= LutTotalCoeff;
            cap_t1   <= LutTrailingOnes;
            ShiftAmt <= LutNumShift;
            ShiftEn  <= 1'b1;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (ShiftAck) begin
            ShiftEn      <= 1'b0;
            TotalCoeff   <= cap_tc;
            TrailingOnes <= cap_t1;
            Done         <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_token_ctrl.sv
// Scoreboard bench for coeff_token_ctrl: directed vectors, monitor pops expectations on Done/Error.
module tb_coeff_token_ctrl;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Start;
  logic signed [4:0] nC;
  logic [15:0]       Window;
  logic              WindowValid;
  logic [2:0]        LutTable;
  logic [3:0]        LutZeros;
  logic [3:0]        LutBits;
  logic [4:0]        LutTotalCoeff;
  logic [1:0]        LutTrailingOnes;
  logic [4:0]        LutNumShift;
  logic              LutHit;
  logic              ShiftEn;
  logic [4:0]        ShiftAmt;
  logic              ShiftAck;
  logic [4:0]        TotalCoeff;
  logic [1:0]        TrailingOnes;
  logic              Done;
  logic              Busy;
  logic              Error;

  always #5 Clk = ~Clk;

  coeff_token_ctrl #(.WIN_W(16)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Start           (Start),
    .nC              (nC),
    .Window          (Window),
    .WindowValid     (WindowValid),
    .LutTable        (LutTable),
    .LutZeros        (LutZeros),
    .LutBits         (LutBits),
    .LutTotalCoeff   (LutTotalCoeff),
    .LutTrailingOnes (LutTrailingOnes),
    .LutNumShift     (LutNumShift),
    .LutHit          (LutHit),
    .ShiftEn         (ShiftEn),
    .ShiftAmt        (ShiftAmt),
    .ShiftAck        (ShiftAck),
    .TotalCoeff      (TotalCoeff),
    .TrailingOnes    (TrailingOnes),
    .Done            (Done),
    .Busy            (Busy),
    .Error           (Error)
  );

  typedef struct {
    logic [4:0] tc;
    logic [1:0] t1;
    logic [4:0] amt;
    logic [2:0] tbl;
    logic [3:0] zeros;
    logic [3:0] bits;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [4:0] last_tc = '0;

  function automatic exp_t mk(input logic [4:0] tc, input logic [1:0] t1, input logic [4:0] amt,
                              input logic [2:0] tbl, input logic [3:0] z, input logic [3:0] b,
                              input logic err);
    exp_t e;
    e.tc = tc; e.t1 = t1; e.amt = amt; e.tbl = tbl; e.zeros = z; e.bits = b; e.err = err;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: snapshots the LUT address and shift amount, then checks results on Done/Error.
  initial begin
    logic [2:0] s_tbl;
    logic [3:0] s_z;
    logic [3:0] s_b;
    logic [4:0] amt0;
    bit         seen;
    exp_t       e;
    s_tbl = '0; s_z = '0; s_b = '0; amt0 = '0; seen = 0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        s_tbl = '0; s_z = '0; s_b = '0; seen = 0;
      end else begin
        if (Busy && !ShiftEn && (LutTable != 0 || LutZeros != 0 || LutBits != 0)) begin
          s_tbl = LutTable; s_z = LutZeros; s_b = LutBits;
        end
        if (ShiftEn) begin
          if (!seen) begin
            amt0 = ShiftAmt;
            seen = 1;
          end else begin
            chk("shift_amt_stable", ShiftAmt, amt0);
          end
        end
        if (Done || Error) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("error_flag", Error, e.err);
            if (!e.err) begin
              chk("total_coeff", TotalCoeff, e.tc);
              chk("trailing_ones", TrailingOnes, e.t1);
              chk("shift_amt", amt0, e.amt);
              chk("lut_table", s_tbl, e.tbl);
              chk("lut_zeros", s_z, e.zeros);
              chk("lut_bits", s_b, e.bits);
            end
          end
          s_tbl = '0; s_z = '0; s_b = '0; seen = 0;
        end
      end
    end
  end

  task automatic run(input logic signed [4:0] nc, input logic [15:0] win,
                     input logic [4:0] ltc, input logic [1:0] lt1, input logic [4:0] lns,
                     input logic hit, input int wvd, input int ackd, input bit poke,
                     input exp_t e);
    int k;
    sb.push_back(e);
    @(negedge Clk);
    nC = nc; Window = win; LutTotalCoeff = ltc; LutTrailingOnes = lt1; LutNumShift = lns;
    LutHit = hit; WindowValid = (wvd == 0); Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    k = 0;
    while (!ShiftEn && !(e.err && !Busy) && k < 40) begin
      if (k == wvd) WindowValid = 1'b1;
      @(negedge Clk);
      k++;
    end
    if (e.err) begin
      chk("error_latency", k, wvd + 3);
      chk("error_no_shift", ShiftEn, 0);
      chk("error_hold_tc", TotalCoeff, last_tc);
      @(negedge Clk);
      chk("error_single_pulse", Error, 0);
      chk("error_no_done", Done, 0);
    end else begin
      chk("shift_latency", k, wvd + 3);
      for (int i = 0; i < ackd; i++) begin
        if (poke && i == 2) Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("shift_held", ShiftEn, 1);
      end
      ShiftAck = 1'b1;
      @(negedge Clk);
      ShiftAck = 1'b0;
      chk("done_after_ack", Done, 1);
      chk("shift_dropped", ShiftEn, 0);
      @(negedge Clk);
      chk("done_one_cycle", Done, 0);
      chk("idle_not_busy", Busy, 0);
      last_tc = e.tc;
    end
    WindowValid = 1'b0;
  endtask

  initial begin
    int k;
    Reset = 1'b1; Start = 1'b0; nC = '0; Window = '0; WindowValid = 1'b0;
    LutTotalCoeff = '0; LutTrailingOnes = '0; LutNumShift = '0; LutHit = 1'b1; ShiftAck = 1'b0;
    repeat (2) @(negedge Clk);
    chk("reset_busy", Busy, 0);
    chk("reset_shift_en", ShiftEn, 0);
    chk("reset_done", Done, 0);
    chk("reset_error", Error, 0);
    chk("reset_outputs", {TotalCoeff, TrailingOnes, ShiftAmt}, 0);
    chk("reset_lut_addr", {LutTable, LutZeros, LutBits}, 0);
    Reset = 1'b0;

    run(5'sd0, 16'h8000, 5'd0, 2'd0, 5'd1, 1'b1, 0, 0, 0, mk(5'd0, 2'd0, 5'd1, 3'd0, 4'd0, 4'd0, 1'b0));
    run(5'sd8, 16'h0C00, 5'd31, 2'd3, 5'd31, 1'b1, 0, 1, 0, mk(5'd0, 2'd0, 5'd6, 3'd3, 4'd4, 4'd8, 1'b0));
    run(5'sd8, 16'h1400, 5'd31, 2'd3, 5'd31, 1'b1, 0, 0, 0, mk(5'd2, 2'd1, 5'd6, 3'd3, 4'd3, 4'd4, 1'b0));
    run(5'sd3, 16'h4A00, 5'd3, 2'd2, 5'd7, 1'b1, 3, 0, 0, mk(5'd3, 2'd2, 5'd7, 3'd1, 4'd1, 4'd2, 1'b0));
    run(5'sd5, 16'h2000, 5'd5, 2'd3, 5'd9, 1'b1, 0, 5, 1, mk(5'd5, 2'd3, 5'd9, 3'd2, 4'd2, 4'd0, 1'b0));
`ifdef COEFF_TOKEN_CTRL_ERR_EN
    run(-5'sd1, 16'h0001, 5'd1, 2'd1, 5'd15, 1'b1, 0, 0, 0, mk(5'd0, 2'd0, 5'd0, 3'd0, 4'd0, 4'd0, 1'b1));
`else
    run(-5'sd1, 16'h0001, 5'd1, 2'd1, 5'd15, 1'b1, 0, 0, 0, mk(5'd1, 2'd1, 5'd15, 3'd4, 4'd15, 4'd0, 1'b0));
`endif
    run(5'sd12, 16'hFC00, 5'd0, 2'd0, 5'd0, 1'b1, 0, 0, 0, mk(5'd16, 2'd3, 5'd6, 3'd3, 4'd0, 4'd15, 1'b0));
    run(-5'sd4, 16'h1000, 5'd2, 2'd0, 5'd4, 1'b1, 0, 2, 0, mk(5'd2, 2'd0, 5'd4, 3'd4, 4'd3, 4'd0, 1'b0));
`ifdef COEFF_TOKEN_CTRL_ERR_EN
    run(5'sd1, 16'h8000, 5'd4, 2'd1, 5'd6, 1'b0, 0, 0, 0, mk(5'd0, 2'd0, 5'd0, 3'd0, 4'd0, 4'd0, 1'b1));
`else
    run(5'sd1, 16'h8000, 5'd4, 2'd1, 5'd6, 1'b0, 0, 0, 0, mk(5'd4, 2'd1, 5'd6, 3'd0, 4'd0, 4'd0, 1'b0));
`endif

    // Abort during SHIFT, with ShiftAck coinciding with Reset; no result is expected.
    @(negedge Clk);
    nC = 5'sd2; Window = 16'h4000; LutTotalCoeff = 5'd7; LutTrailingOnes = 2'd3; LutNumShift = 5'd8;
    LutHit = 1'b1; WindowValid = 1'b1; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    k = 0;
    while (!ShiftEn && k < 40) begin
      @(negedge Clk);
      k++;
    end
    chk("abort_reached_shift", ShiftEn, 1);
    Reset = 1'b1; ShiftAck = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; ShiftAck = 1'b0; WindowValid = 1'b0;
    chk("abort_shift_en", ShiftEn, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_outputs", {TotalCoeff, TrailingOnes, ShiftAmt}, 0);
    chk("abort_lut_addr", {LutTable, LutZeros, LutBits}, 0);
    @(negedge Clk);
    chk("abort_no_late_done", Done, 0);
    last_tc = '0;

    run(5'sd2, 16'h6000, 5'd6, 2'd2, 5'd3, 1'b1, 0, 0, 0, mk(5'd6, 2'd2, 5'd3, 3'd1, 4'd1, 4'd8, 1'b0));

    repeat (3) @(negedge Clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
